// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider: each channel produces a square out_clk and a
// toggle strobe from in_clk, with divide updates deferred to the next toggle boundary.
module clock_divider_multi #(
   parameter int              NCH         = 4,
   parameter int              CW          = 25,
   parameter logic [CW-1:0]   DEFAULT_DIV = CW'(24_999_999),
   localparam int             CHW         = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           in_clk,
   input  logic           reset,
   input  logic [NCH-1:0] en,
   input  logic           resync,
   input  logic           wr_en,
   input  logic [CHW-1:0] wr_chan,
   input  logic [CW-1:0]  wr_div,
   output logic [NCH-1:0] out_clk,
   output logic [NCH-1:0] tick,
   output logic [NCH-1:0] wr_pending
);

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_ch
         logic [CW-1:0] cnt_q, cnt_d;
         logic [CW-1:0] active_q, active_d;
         logic [CW-1:0] pend_div_q, pend_div_d;
         logic          out_q, out_d;
         logic          tick_q, tick_d;
         logic          pend_q, pend_d;
         logic          wr_hit;
         logic          wrap;

         // Out-of-range channel numbers never match any gi, so such writes are dropped.
         assign wr_hit = wr_en && (wr_chan == CHW'(gi));
         assign wrap   = en[gi] && (cnt_q == active_q);

         always_comb begin
            cnt_d      = cnt_q;
            active_d   = active_q;
            pend_div_d = pend_div_q;
            out_d      = out_q;
            tick_d     = 1'b0;
            pend_d     = pend_q;

            if (resync) begin
               cnt_d  = '0;
               out_d  = 1'b0;
               pend_d = 1'b0;
               if (wr_hit) begin
                  active_d = wr_div;
               end else if (pend_q) begin
                  active_d = pend_div_q;
               end
            end else begin
               if (!en[gi]) begin
                  cnt_d = '0;
                  out_d = 1'b0;
               end else if (wrap) begin
                  cnt_d  = '0;
                  out_d  = ~out_q;
                  tick_d = 1'b1;
                  if (pend_q) begin
                     active_d = pend_div_q;
                     pend_d   = 1'b0;
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end

               // Mid-period writes wait for the wrap so the running half-period finishes intact.
               if (wr_hit) begin
                  if (en[gi] && !wrap) begin
                     pend_div_d = wr_div;
                     pend_d     = 1'b1;
                  end else begin
                     active_d = wr_div;
                     pend_d   = 1'b0;
                  end
               end
            end
         end

         always_ff @(posedge in_clk) begin
            if (reset) begin
               cnt_q      <= '0;
               active_q   <= DEFAULT_DIV;
               pend_div_q <= '0;
               out_q      <= 1'b0;
               tick_q     <= 1'b0;
               pend_q     <= 1'b0;
            end else begin
               cnt_q      <= cnt_d;
               active_q   <= active_d;
               pend_div_q <= pend_div_d;
               out_q      <= out_d;
               tick_q     <= tick_d;
               pend_q     <= pend_d;
            end
         end

         assign out_clk[gi]    = out_q;
         assign tick[gi]       = tick_q;
         assign wr_pending[gi] = pend_q;
      end
   endgenerate

endmodule

// File: tb/tb_clock_divider_multi.sv
// Bench for clock_divider_multi: expected toggle events are queued per scenario and
// matched edge by edge against tick, out_clk and wr_pending.
module tb_clock_divider_multi;
   localparam int NCH = 5;
   localparam int CW  = 25;

   typedef struct {
      int   edge_n;
      int   ch;
      logic lvl;
      logic tk;
   } ev_t;

   logic           in_clk = 1'b0;
   logic           reset;
   logic [NCH-1:0] en;
   logic           resync;
   logic           wr_en;
   logic [2:0]     wr_chan;
   logic [CW-1:0]  wr_div;
   logic [NCH-1:0] out_clk;
   logic [NCH-1:0] tick;
   logic [NCH-1:0] wr_pending;

   int             n_vec = 0;
   int             n_err = 0;
   ev_t            exp_q[$];
   logic [NCH-1:0] lvl_exp;
   logic [NCH-1:0] pend_exp;

   clock_divider_multi #(
      .NCH         (NCH),
      .CW          (CW),
      .DEFAULT_DIV (25'd3)
   ) dut (
      .in_clk     (in_clk),
      .reset      (reset),
      .en         (en),
      .resync     (resync),
      .wr_en      (wr_en),
      .wr_chan    (wr_chan),
      .wr_div     (wr_div),
      .out_clk    (out_clk),
      .tick       (tick),
      .wr_pending (wr_pending)
   );

   always #5 in_clk = ~in_clk;

   task automatic step();
      @(posedge in_clk);
      #1;
   endtask

   task automatic wr(input int ch, input int val);
      wr_en   = 1'b1;
      wr_chan = 3'(ch);
      wr_div  = CW'(val);
      step();
      wr_en   = 1'b0;
      $display("write ch%0d div=%0d", ch, val);
   endtask

   // Keep the queue sorted by (edge, channel) so the per-edge scan only looks at the head.
   task automatic push(input int ch, input int edge_n, input logic lvl, input logic tk);
      ev_t ev;
      int  i;
      ev.edge_n = edge_n;
      ev.ch     = ch;
      ev.lvl    = lvl;
      ev.tk     = tk;
      i = 0;
      while (i < exp_q.size() && (exp_q[i].edge_n < edge_n ||
             (exp_q[i].edge_n == edge_n && exp_q[i].ch < ch)))
         i++;
      exp_q.insert(i, ev);
   endtask

   task automatic push_run(input int ch, input int start, input int half, input int last);
      for (int j = 1; start + half * j <= last; j++)
         push(ch, start + half * j, (j % 2) == 1, 1'b1);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      en    = '1;
      repeat (3) step();
      n_vec++;
      if (out_clk !== '0) begin n_err++; $display("FAIL reset out_clk: got %b expected 0", out_clk); end
      n_vec++;
      if (tick !== '0) begin n_err++; $display("FAIL reset tick: got %b expected 0", tick); end
      n_vec++;
      if (wr_pending !== '0) begin n_err++; $display("FAIL reset wr_pending: got %b expected 0", wr_pending); end
      reset = 1'b0;
      en    = '0;
      step();
      n_vec++;
      if (out_clk !== '0 || tick !== '0) begin
         n_err++;
         $display("FAIL reset idle: out_clk=%b tick=%b expected 0/0", out_clk, tick);
      end
      $display("reset checked");
   endtask

   task automatic test_default_div();
      ev_t  ev;
      logic exp_tk;
      exp_q.delete(); lvl_exp = '0; pend_exp = '0;
      en = 5'b00001;
      push_run(0, 0, 4, 40);
      for (int e = 1; e <= 40; e++) begin
         step();
         for (int c = 0; c < NCH; c++) begin
            exp_tk = 1'b0;
            if (exp_q.size() != 0 && exp_q[0].edge_n == e && exp_q[0].ch == c) begin
               ev = exp_q.pop_front(); exp_tk = ev.tk; lvl_exp[c] = ev.lvl;
            end
            n_vec++;
            if (tick[c] !== exp_tk || out_clk[c] !== lvl_exp[c]) begin
               n_err++;
               $display("FAIL default_div e%0d ch%0d: tick/out=%b/%b expected %b/%b", e, c, tick[c], out_clk[c], exp_tk, lvl_exp[c]);
            end
         end
         n_vec++;
         if (wr_pending !== pend_exp) begin n_err++; $display("FAIL default_div e%0d wr_pending: got %b expected %b", e, wr_pending, pend_exp); end
      end
      n_vec++;
      if (exp_q.size() != 0) begin n_err++; $display("FAIL default_div leftover events: got %0d expected 0", exp_q.size()); end
      $display("default_div scenario done");
   endtask

   task automatic test_div0();
      ev_t  ev;
      logic exp_tk;
      en = '0; step();
      wr(1, 0);
      exp_q.delete(); lvl_exp = '0; pend_exp = '0;
      en = 5'b00010;
      push_run(1, 0, 1, 8);
      for (int e = 1; e <= 8; e++) begin
         step();
         for (int c = 0; c < NCH; c++) begin
            exp_tk = 1'b0;
            if (exp_q.size() != 0 && exp_q[0].edge_n == e && exp_q[0].ch == c) begin
               ev = exp_q.pop_front(); exp_tk = ev.tk; lvl_exp[c] = ev.lvl;
            end
            n_vec++;
            if (tick[c] !== exp_tk || out_clk[c] !== lvl_exp[c]) begin
               n_err++;
               $display("FAIL div0 e%0d ch%0d: tick/out=%b/%b expected %b/%b", e, c, tick[c], out_clk[c], exp_tk, lvl_exp[c]);
            end
         end
         n_vec++;
         if (wr_pending !== pend_exp) begin n_err++; $display("FAIL div0 e%0d wr_pending: got %b expected %b", e, wr_pending, pend_exp); end
      end
      n_vec++;
      if (exp_q.size() != 0) begin n_err++; $display("FAIL div0 leftover events: got %0d expected 0", exp_q.size()); end
      $display("div0 scenario done");
   endtask

   task automatic test_pending();
      ev_t  ev;
      logic exp_tk;
      en = '0; step();
      wr(0, 9);
      exp_q.delete(); lvl_exp = '0;
      en = 5'b00001;
      push(0, 10, 1'b1, 1'b1);
      push(0, 20, 1'b0, 1'b1);
      push_run(0, 20, 3, 33);
      for (int e = 1; e <= 33; e++) begin
         step();
         pend_exp = (e >= 16 && e <= 19) ? 5'b00001 : 5'b00000;
         for (int c = 0; c < NCH; c++) begin
            exp_tk = 1'b0;
            if (exp_q.size() != 0 && exp_q[0].edge_n == e && exp_q[0].ch == c) begin
               ev = exp_q.pop_front(); exp_tk = ev.tk; lvl_exp[c] = ev.lvl;
            end
            n_vec++;
            if (tick[c] !== exp_tk || out_clk[c] !== lvl_exp[c]) begin
               n_err++;
               $display("FAIL pending e%0d ch%0d: tick/out=%b/%b expected %b/%b", e, c, tick[c], out_clk[c], exp_tk, lvl_exp[c]);
            end
         end
         n_vec++;
         if (wr_pending !== pend_exp) begin n_err++; $display("FAIL pending e%0d wr_pending: got %b expected %b", e, wr_pending, pend_exp); end
         if (e == 15) begin wr_en = 1'b1; wr_chan = 3'd0; wr_div = 25'd2; $display("write ch0 div=2 mid-period"); end
         if (e == 16) wr_en = 1'b0;
      end
      n_vec++;
      if (exp_q.size() != 0) begin n_err++; $display("FAIL pending leftover events: got %0d expected 0", exp_q.size()); end
      $display("pending scenario done");
   endtask

   task automatic test_back_to_back();
      ev_t  ev;
      logic exp_tk;
      en = '0; step();
      wr(2, 5);
      exp_q.delete(); lvl_exp = '0;
      en = 5'b00100;
      push_run(2, 0, 6, 12);
      push(2, 17, 1'b1, 1'b1);
      push(2, 22, 1'b0, 1'b1);
      push(2, 24, 1'b1, 1'b1);
      push(2, 26, 1'b0, 1'b1);
      push(2, 28, 1'b1, 1'b1);
      for (int e = 1; e <= 28; e++) begin
         step();
         pend_exp = (e >= 8 && e <= 11) ? 5'b00100 : 5'b00000;
         for (int c = 0; c < NCH; c++) begin
            exp_tk = 1'b0;
            if (exp_q.size() != 0 && exp_q[0].edge_n == e && exp_q[0].ch == c) begin
               ev = exp_q.pop_front(); exp_tk = ev.tk; lvl_exp[c] = ev.lvl;
            end
            n_vec++;
            if (tick[c] !== exp_tk || out_clk[c] !== lvl_exp[c]) begin
               n_err++;
               $display("FAIL back_to_back e%0d ch%0d: tick/out=%b/%b expected %b/%b", e, c, tick[c], out_clk[c], exp_tk, lvl_exp[c]);
            end
         end
         n_vec++;
         if (wr_pending !== pend_exp) begin n_err++; $display("FAIL back_to_back e%0d wr_pending: got %b expected %b", e, wr_pending, pend_exp); end
         if (e == 7)  begin wr_en = 1'b1; wr_chan = 3'd2; wr_div = 25'd7; $display("write ch2 div=7"); end
         if (e == 8)  begin wr_div = 25'd4; $display("write ch2 div=4"); end
         if (e == 9)  wr_en = 1'b0;
         if (e == 21) begin wr_en = 1'b1; wr_chan = 3'd2; wr_div = 25'd1; $display("write ch2 div=1 on wrap"); end
         if (e == 22) wr_en = 1'b0;
      end
      n_vec++;
      if (exp_q.size() != 0) begin n_err++; $display("FAIL back_to_back leftover events: got %0d expected 0", exp_q.size()); end
      $display("back_to_back scenario done");
   endtask

   task automatic test_resync();
      ev_t  ev;
      logic exp_tk;
      en = '0; step();
      wr(0, 1); wr(1, 2); wr(2, 3); wr(3, 4);
      exp_q.delete(); lvl_exp = '0; pend_exp = '0;
      en = 5'b01111;
      for (int c = 0; c < 4; c++) begin
         push_run(c, 0, c + 2, 10);
         push(c, 11, 1'b0, 1'b0);
         push_run(c, 11, c + 2, 30);
      end
      for (int e = 1; e <= 30; e++) begin
         step();
         for (int c = 0; c < NCH; c++) begin
            exp_tk = 1'b0;
            if (exp_q.size() != 0 && exp_q[0].edge_n == e && exp_q[0].ch == c) begin
               ev = exp_q.pop_front(); exp_tk = ev.tk; lvl_exp[c] = ev.lvl;
            end
            n_vec++;
            if (tick[c] !== exp_tk || out_clk[c] !== lvl_exp[c]) begin
               n_err++;
               $display("FAIL resync e%0d ch%0d: tick/out=%b/%b expected %b/%b", e, c, tick[c], out_clk[c], exp_tk, lvl_exp[c]);
            end
         end
         n_vec++;
         if (wr_pending !== pend_exp) begin n_err++; $display("FAIL resync e%0d wr_pending: got %b expected %b", e, wr_pending, pend_exp); end
         if (e == 10) begin resync = 1'b1; $display("resync pulse"); end
         if (e == 11) resync = 1'b0;
         if (e == 13) begin wr_en = 1'b1; wr_chan = 3'd5; wr_div = '0; $display("write ch5 (out of range)"); end
         if (e == 14) begin wr_chan = 3'd7; $display("write ch7 (out of range)"); end
         if (e == 15) wr_en = 1'b0;
      end
      n_vec++;
      if (exp_q.size() != 0) begin n_err++; $display("FAIL resync leftover events: got %0d expected 0", exp_q.size()); end
      $display("resync scenario done");
   endtask

   task automatic test_enable_reset();
      ev_t  ev;
      logic exp_tk;
      en = '0; step();
      wr(0, 3);
      exp_q.delete(); lvl_exp = '0;
      en = 5'b00001;
      push(0, 4,  1'b1, 1'b1);
      push(0, 6,  1'b0, 1'b0);
      push(0, 10, 1'b1, 1'b1);
      push(0, 14, 1'b0, 1'b1);
      push(0, 16, 1'b1, 1'b1);
      push(0, 17, 1'b0, 1'b0);
      push_run(0, 17, 4, 30);
      for (int e = 1; e <= 30; e++) begin
         step();
         pend_exp = (e >= 12 && e <= 13) ? 5'b00001 : 5'b00000;
         for (int c = 0; c < NCH; c++) begin
            exp_tk = 1'b0;
            if (exp_q.size() != 0 && exp_q[0].edge_n == e && exp_q[0].ch == c) begin
               ev = exp_q.pop_front(); exp_tk = ev.tk; lvl_exp[c] = ev.lvl;
            end
            n_vec++;
            if (tick[c] !== exp_tk || out_clk[c] !== lvl_exp[c]) begin
               n_err++;
               $display("FAIL enable_reset e%0d ch%0d: tick/out=%b/%b expected %b/%b", e, c, tick[c], out_clk[c], exp_tk, lvl_exp[c]);
            end
         end
         n_vec++;
         if (wr_pending !== pend_exp) begin n_err++; $display("FAIL enable_reset e%0d wr_pending: got %b expected %b", e, wr_pending, pend_exp); end
         if (e == 5)  begin en = 5'b00000; $display("drop en[0]"); end
         if (e == 6)  en = 5'b00001;
         if (e == 11) begin wr_en = 1'b1; wr_chan = 3'd0; wr_div = 25'd1; $display("write ch0 div=1"); end
         if (e == 12) wr_en = 1'b0;
         if (e == 16) begin reset = 1'b1; $display("reset while running"); end
         if (e == 17) reset = 1'b0;
      end
      n_vec++;
      if (exp_q.size() != 0) begin n_err++; $display("FAIL enable_reset leftover events: got %0d expected 0", exp_q.size()); end
      $display("enable_reset scenario done");
   endtask

   initial begin
      reset   = 1'b1;
      en      = '0;
      resync  = 1'b0;
      wr_en   = 1'b0;
      wr_chan = '0;
      wr_div  = '0;
      test_reset();
      test_default_div();
      test_div0();
      test_pending();
      test_back_to_back();
      test_resync();
      test_enable_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
